// File: rtl/mem_pkg.sv
// Shared memory-request types and limits for the single-port RAM controller.
package mem_pkg;

  localparam int unsigned MaxReadLatency = 4;

  // Default bus widths used by the request struct.
  localparam int unsigned MemAddrWidth = 32;
  localparam int unsigned MemDataWidth = 32;

  typedef struct packed {
    logic                    we;
    logic [MemAddrWidth-1:0] addr;
    logic [MemDataWidth-1:0] wdata;
  } mem_req_t;

  // Response buffer depth needed to sustain one read per cycle.
  function automatic int unsigned resp_depth(int unsigned read_latency);
    return read_latency + 2;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with output taken from storage registers (no push-to-pop bypass).
module fifo_sync #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_push   = push & (cnt_q != CntW'(Depth));
  assign do_pop    = pop & (cnt_q != '0);
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wptr_d = do_push ? next_ptr(wptr_q) : wptr_q;
    rptr_d = do_pop ? next_ptr(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/spram_port_ctrl.sv
// Request/response front end for a single-port RAM with fixed read latency.
// Reads are credit-limited so every response always has a buffer slot.
module spram_port_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AddrBusWidth = 32,
  parameter int unsigned DataBusWidth = 32,
  parameter int unsigned ReadLatency  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AddrBusWidth-1:0] req_addr,
  input  logic [DataBusWidth-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DataBusWidth-1:0] resp_data,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [AddrBusWidth-1:0] mem_addr,
  output logic [DataBusWidth-1:0] mem_wdata,
  input  logic [DataBusWidth-1:0] mem_rdata,
  output logic                    busy
);

  localparam int unsigned RespDepth = resp_depth(ReadLatency);
  localparam int unsigned CreditW   = $clog2(RespDepth + 1);

  if (ReadLatency > MaxReadLatency) begin : g_bad_latency
    $error("spram_port_ctrl: ReadLatency must be in 0..4");
  end

  logic               credit_ok;
  logic [CreditW-1:0] credit_q, credit_d;
  logic               accept;
  logic               trk_exit;
  logic               inflight_any;
  logic               fifo_valid;
  logic               pop;

  // Writes never need a response slot, so only reads are credit-gated.
  assign credit_ok = (credit_q < CreditW'(RespDepth));
  assign req_ready = ~rst & (req_we | credit_ok);
  assign accept    = req_valid & req_ready;

  assign mem_re    = accept & ~req_we;
  assign mem_we    = accept & req_we;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  if (ReadLatency == 0) begin : g_no_trk
    // Zero-latency RAM: data is on mem_rdata in the accept cycle itself.
    assign trk_exit     = mem_re;
    assign inflight_any = 1'b0;
  end else begin : g_trk
    logic [ReadLatency-1:0] trk_q, trk_d;

    // Shift the read-valid marker one stage per cycle.
    always_comb begin
      trk_d    = '0;
      trk_d[0] = mem_re;
      for (int unsigned i = 1; i < ReadLatency; i++) begin
        trk_d[i] = trk_q[i-1];
      end
    end

    // Tracker register; reset discards any reads still in flight.
    always_ff @(posedge clk) begin
      if (rst) trk_q <= '0;
      else     trk_q <= trk_d;
    end

    assign trk_exit     = trk_q[ReadLatency-1];
    assign inflight_any = |trk_q;
  end

  assign resp_valid = fifo_valid & ~rst;
  assign pop        = resp_valid & resp_ready;
  assign busy       = ~rst & (inflight_any | resp_valid);

  // Credits count reads issued but not yet consumed.
  always_comb begin
    credit_d = credit_q;
    unique case ({mem_re, pop})
      2'b10:   credit_d = credit_q + CreditW'(1);
      2'b01:   credit_d = credit_q - CreditW'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Credit counter register.
  always_ff @(posedge clk) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

  fifo_sync #(
    .Depth(RespDepth),
    .Width(DataBusWidth)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (trk_exit),
    .push_data(mem_rdata),
    .pop      (pop),
    .out_valid(fifo_valid),
    .out_data (resp_data)
  );

endmodule
